// File: rtl/nnrv_ifq.sv
// rtl/nnrv_ifq.sv - instruction fetch prefetch queue
//
// Fetches 32-bit instructions from a one-cycle-latency RAM into a DEPTH-entry
// queue of {pc, instr} and presents the head to decode.
//
// Ports:
//   i_clk, i_rst      clock, synchronous active-high reset
//   o_ram_rd_*        fetch request (address, strobe, byte mask)
//   i_ram_rd_data     fetch data, valid the cycle after o_ram_rd_en
//   o_id_valid/instr/cur_pc, i_id_ready   queue head handshake to decode
//   i_id_jmp, i_id_jmp_pc                 redirect request and target
//   o_id_fault        misaligned redirect target (NNRV_IFQ_MISALIGN_TRAP_EN only)
//
// Build option: define NNRV_IFQ_MISALIGN_TRAP_EN to trap misaligned redirect
// targets (HALT + o_id_fault) instead of silently clearing pc[1:0].
module nnrv_ifq #(
  parameter int              XLEN        = 32,
  parameter int              INSTR_WIDTH = 32,
  parameter int              ADDR_WIDTH  = 8,
  parameter int              DEPTH       = 4,
  parameter logic [XLEN-1:0] RESET_PC    = '0
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  output logic [ADDR_WIDTH-1:0]  o_ram_rd_addr,
  output logic                   o_ram_rd_en,
  output logic [3:0]             o_ram_rd_mask,
  input  logic [INSTR_WIDTH-1:0] i_ram_rd_data,
  output logic                   o_id_valid,
  output logic [INSTR_WIDTH-1:0] o_id_instr,
  output logic [XLEN-1:0]        o_id_cur_pc,
`ifdef NNRV_IFQ_MISALIGN_TRAP_EN
  output logic                   o_id_fault,
`endif
  input  logic                   i_id_ready,
  input  logic                   i_id_jmp,
  input  logic [XLEN-1:0]        i_id_jmp_pc
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [XLEN-1:0]        pc_mem    [DEPTH];
  logic [INSTR_WIDTH-1:0] instr_mem [DEPTH];
  logic [PW-1:0]          wr_ptr, rd_ptr;
  logic [CW-1:0]          count;
  logic                   inflight;
  logic [XLEN-1:0]        inflight_pc;
  logic [XLEN-1:0]        fetch_pc;
  logic [XLEN-1:0]        jmp_target;
  logic                   run;
  logic                   push, pop, issue;
  logic [CW:0]            occupancy, limit;

`ifdef NNRV_IFQ_MISALIGN_TRAP_EN
  typedef enum logic {S_RUN, S_HALT} state_t;
  state_t state_q, state_d;
  logic   misaligned;

  assign misaligned = (i_id_jmp_pc[1:0] != 2'b00);
  assign jmp_target = i_id_jmp_pc;

  always_ff @(posedge i_clk) begin
    if (i_rst) state_q <= S_RUN;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (i_id_jmp) state_d = misaligned ? S_HALT : S_RUN;
  end

  always_comb begin
    run        = (state_q == S_RUN);
    o_id_fault = (state_q == S_HALT);
  end
`else
  logic unused_jmp_lsb;
  assign unused_jmp_lsb = ^i_id_jmp_pc[1:0];
  assign jmp_target     = {i_id_jmp_pc[XLEN-1:2], 2'b00};
  assign run            = 1'b1;
`endif

  assign o_id_valid  = !i_rst && (count != '0);
  assign o_id_instr  = instr_mem[rd_ptr];
  assign o_id_cur_pc = pc_mem[rd_ptr];

  // A redirect outranks everything: it suppresses pop, push and issue.
  assign pop  = o_id_valid && i_id_ready && !i_id_jmp;
  assign push = inflight && !i_id_jmp;

  // The in-flight slot is reserved up front, so a response never lands in a
  // full queue; a same-cycle pop frees one slot for this cycle's issue.
  assign occupancy = {1'b0, count} + {{CW{1'b0}}, inflight};
  assign limit     = (CW + 1)'(DEPTH) + {{CW{1'b0}}, pop};
  assign issue     = !i_rst && run && !i_id_jmp && (occupancy < limit);

  assign o_ram_rd_en   = issue;
  assign o_ram_rd_addr = fetch_pc[ADDR_WIDTH-1:0];
  assign o_ram_rd_mask = 4'b1111;

  always_ff @(posedge i_clk) begin
    if (push) begin
      pc_mem[wr_ptr]    <= inflight_pc;
      instr_mem[wr_ptr] <= i_ram_rd_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      inflight    <= 1'b0;
      inflight_pc <= '0;
      fetch_pc    <= RESET_PC;
    end else if (i_id_jmp) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      inflight    <= 1'b0;
      fetch_pc    <= jmp_target;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count    <= count + CW'(push) - CW'(pop);
      inflight <= issue;
      if (issue) begin
        inflight_pc <= fetch_pc;
        fetch_pc    <= fetch_pc + XLEN'(4);
      end
    end
  end

endmodule

// File: tb/tb_nnrv_ifq.sv
// tb/tb_nnrv_ifq.sv - directed vector bench for nnrv_ifq
module tb_nnrv_ifq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  ram_addr;
  logic        ram_en;
  logic [3:0]  ram_mask;
  logic [31:0] ram_data = '0;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic        id_ready = 1'b0;
  logic        id_jmp = 1'b0;
  logic [31:0] id_jmp_pc = '0;
`ifdef NNRV_IFQ_MISALIGN_TRAP_EN
  logic        id_fault;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  nnrv_ifq dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .o_ram_rd_addr (ram_addr),
    .o_ram_rd_en   (ram_en),
    .o_ram_rd_mask (ram_mask),
    .i_ram_rd_data (ram_data),
    .o_id_valid    (id_valid),
    .o_id_instr    (id_instr),
    .o_id_cur_pc   (id_pc),
`ifdef NNRV_IFQ_MISALIGN_TRAP_EN
    .o_id_fault    (id_fault),
`endif
    .i_id_ready    (id_ready),
    .i_id_jmp      (id_jmp),
    .i_id_jmp_pc   (id_jmp_pc)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [7:0] a);
    return {16'hC0DE, 8'h5A, a};
  endfunction

  // One-cycle-latency RAM
  always @(posedge clk) if (ram_en) ram_data <= mem_word(ram_addr);

  typedef struct {
    logic        rst, rdy, jmp;
    logic [31:0] jpc;
    logic        en;
    logic [7:0]  addr;
    logic        vld;
    logic [31:0] pc;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic rd, input logic j, input logic [31:0] jp,
                     input logic e, input logic [7:0] a, input logic v, input logic [31:0] p);
    vec_t t;
    t.rst = r; t.rdy = rd; t.jmp = j; t.jpc = jp;
    t.en = e; t.addr = a; t.vld = v; t.pc = p;
    vecs.push_back(t);
  endtask

  task automatic check(input string name, input int step, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s step %0d: got 0x%08h, required 0x%08h", name, step, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic rd, input logic j, input logic [31:0] jp);
    @(negedge clk);
    rst = r; id_ready = rd; id_jmp = j; id_jmp_pc = jp;
    #1;
  endtask

  initial begin
    // reset
    add(1,1,0,0, 0,8'h00,0,0);
    add(1,1,0,0, 0,8'h00,0,0);
    // streaming with ready high
    add(0,1,0,0, 1,8'h00,0,0);
    add(0,1,0,0, 1,8'h04,0,0);
    add(0,1,0,0, 1,8'h08,1,32'h0);
    add(0,1,0,0, 1,8'h0C,1,32'h4);
    add(0,1,0,0, 1,8'h10,1,32'h8);
    // reset while a fetch is in flight
    add(1,0,0,0, 0,8'h00,0,0);
    // stall 10 cycles: queue fills to 4, fetch stops, head held at 0
    add(0,0,0,0, 1,8'h00,0,0);
    add(0,0,0,0, 1,8'h04,0,0);
    add(0,0,0,0, 1,8'h08,1,32'h0);
    add(0,0,0,0, 1,8'h0C,1,32'h0);
    for (int i = 0; i < 6; i++) add(0,0,0,0, 0,8'h00,1,32'h0);
    // drain in order
    add(0,1,0,0, 1,8'h10,1,32'h0);
    add(0,1,0,0, 1,8'h14,1,32'h4);
    add(0,1,0,0, 1,8'h18,1,32'h8);
    add(0,1,0,0, 1,8'h1C,1,32'hC);
    add(0,1,0,0, 1,8'h20,1,32'h10);
    // jump with 3 queued + 1 in flight
    add(1,0,0,0, 0,8'h00,0,0);
    add(0,0,0,0, 1,8'h00,0,0);
    add(0,0,0,0, 1,8'h04,0,0);
    add(0,0,0,0, 1,8'h08,1,32'h0);
    add(0,0,0,0, 1,8'h0C,1,32'h0);
    add(0,0,1,32'h40, 0,8'h00,1,32'h0);
    add(0,0,0,0, 1,8'h40,0,0);
    add(0,0,0,0, 1,8'h44,0,0);
    add(0,0,0,0, 1,8'h48,1,32'h40);
    add(0,0,0,0, 1,8'h4C,1,32'h40);
    // jump together with ready and valid; target above the RAM address range
    add(0,1,1,32'h100, 0,8'h00,1,32'h40);
    add(0,1,0,0, 1,8'h00,0,0);
    add(0,1,0,0, 1,8'h04,0,0);
    add(0,1,0,0, 1,8'h08,1,32'h100);
    add(0,1,0,0, 1,8'h0C,1,32'h104);
`ifndef NNRV_IFQ_MISALIGN_TRAP_EN
    // misaligned target is aligned down
    add(0,1,1,32'h43, 0,8'h00,1,32'h108);
    add(0,1,0,0, 1,8'h40,0,0);
    add(0,1,0,0, 1,8'h44,0,0);
    add(0,1,0,0, 1,8'h48,1,32'h40);
`endif

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst, vecs[i].rdy, vecs[i].jmp, vecs[i].jpc);
      check("rd_en", i, 32'(ram_en), 32'(vecs[i].en));
      if (vecs[i].en) check("rd_addr", i, 32'(ram_addr), 32'(vecs[i].addr));
      check("valid", i, 32'(id_valid), 32'(vecs[i].vld));
      if (vecs[i].vld) begin
        check("cur_pc", i, id_pc, vecs[i].pc);
        check("instr", i, id_instr, mem_word(vecs[i].pc[7:0]));
      end
      check("rd_mask", i, 32'(ram_mask), 32'hF);
    end

`ifdef NNRV_IFQ_MISALIGN_TRAP_EN
    drive(0,1,1,32'h42);
    check("fault_pre", 900, 32'(id_fault), 32'h0);
    for (int k = 0; k < 4; k++) begin
      drive(0,1,0,0);
      check("fault_set", 901 + k, 32'(id_fault), 32'h1);
      check("halt_rd_en", 901 + k, 32'(ram_en), 32'h0);
      check("halt_valid", 901 + k, 32'(id_valid), 32'h0);
    end
    drive(0,1,1,32'h80);
    drive(0,1,0,0);
    check("fault_clr", 910, 32'(id_fault), 32'h0);
    check("resume_en", 910, 32'(ram_en), 32'h1);
    check("resume_addr", 910, 32'(ram_addr), 32'h80);
    drive(0,1,0,0);
    drive(0,1,0,0);
    check("resume_valid", 912, 32'(id_valid), 32'h1);
    check("resume_pc", 912, id_pc, 32'h80);
    check("resume_instr", 912, id_instr, mem_word(8'h80));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
